// File: rtl/distance_filter.sv
// Median-of-three distance filter for an ultrasonic ranger.
// Range-gates raw samples, tracks stale data and counts rejects.
module distance_filter #(
    parameter int unsigned MIN_CM       = 2,
    parameter int unsigned MAX_CM       = 400,
    parameter int unsigned DEFAULT_CM   = 25,
    parameter int unsigned STALE_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_cm,
    output logic        sample_ready,
    output logic [15:0] dist_cm,
    output logic        dist_valid,
    output logic        stale,
    output logic [7:0]  reject_cnt
);

    localparam logic [15:0] MIN_V   = 16'(MIN_CM);
    localparam logic [15:0] MAX_V   = 16'(MAX_CM);
    localparam logic [15:0] DEF_V   = 16'(DEFAULT_CM);
    localparam logic [31:0] STALE_V = 32'(STALE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        MEDIAN = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] sample_q;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [1:0]  fill;
    logic [31:0] stale_cnt;

    logic        in_range;
    logic        accept;
    logic        stale_hit;
    logic [15:0] lo01;
    logic [15:0] hi01;
    logic [15:0] mid_hi;
    logic [15:0] median;

    // Range gate on the latched sample and stale-timeout detection
    always_comb begin
        in_range  = (sample_q >= MIN_V) && (sample_q <= MAX_V);
        accept    = (state == CHECK) && in_range;
        stale_hit = !accept && (stale_cnt == STALE_V - 32'd1);
    end

    // Three-input median: max(min(w0,w1), min(max(w0,w1),w2))
    always_comb begin
        lo01   = (w0 < w1) ? w0 : w1;
        hi01   = (w0 < w1) ? w1 : w0;
        mid_hi = (hi01 < w2) ? hi01 : w2;
        median = (lo01 > mid_hi) ? lo01 : mid_hi;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sample_ready <= 1'b1;
            sample_q     <= 16'd0;
            dist_cm      <= DEF_V;
            dist_valid   <= 1'b0;
            reject_cnt   <= 8'd0;
            w0           <= 16'd0;
            w1           <= 16'd0;
            w2           <= 16'd0;
        end else begin
            dist_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        sample_q     <= sample_cm;
                        sample_ready <= 1'b0;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    if (in_range) begin
                        w2    <= w1;
                        w1    <= w0;
                        w0    <= sample_q;
                        state <= MEDIAN;
                    end else begin
                        if (reject_cnt != 8'hFF) begin
                            reject_cnt <= reject_cnt + 8'd1;
                        end
                        sample_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                MEDIAN: begin
                    dist_cm      <= (fill == 2'd3) ? median : w0;
                    dist_valid   <= 1'b1;
                    sample_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    sample_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Window occupancy and stale timer; an accepted sample wins over timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            fill      <= 2'd0;
            stale_cnt <= 32'd0;
            stale     <= 1'b0;
        end else if (accept) begin
            fill      <= (fill == 2'd3) ? 2'd3 : fill + 2'd1;
            stale_cnt <= 32'd0;
            stale     <= 1'b0;
        end else if (stale_cnt < STALE_V) begin
            stale_cnt <= stale_cnt + 32'd1;
            if (stale_hit) begin
                stale <= 1'b1;
                fill  <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_distance_filter.sv
// Directed scoreboard bench for distance_filter.
// Expected distances come from a sort-based reference model.
module tb_distance_filter;

    localparam int STALE = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_cm = 16'd0;
    logic        sample_ready;
    logic [15:0] dist_cm;
    logic        dist_valid;
    logic        stale;
    logic [7:0]  reject_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    logic [15:0] sb[$];
    logic [15:0] mw[3];
    int          mfill;
    int          mrej;

    distance_filter #(
        .MIN_CM(2),
        .MAX_CM(400),
        .DEFAULT_CM(25),
        .STALE_CYCLES(STALE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_valid(sample_valid),
        .sample_cm(sample_cm),
        .sample_ready(sample_ready),
        .dist_cm(dist_cm),
        .dist_valid(dist_valid),
        .stale(stale),
        .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mid3(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0] s[3];
        logic [15:0] t;
        s[0] = a; s[1] = b; s[2] = c;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[1];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mw[0] = 16'd0; mw[1] = 16'd0; mw[2] = 16'd0;
        mfill = 0;
        mrej = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        tick(2);
        reset = 1'b0;
        model_clear();
    endtask

    // Drive one strobe cycle and record the expected result
    task automatic send(input logic [15:0] v);
        sample_valid = 1'b1;
        sample_cm = v;
        if (v >= 16'd2 && v <= 16'd400) begin
            mw[2] = mw[1]; mw[1] = mw[0]; mw[0] = v;
            if (mfill < 3) mfill++;
            sb.push_back((mfill == 3) ? mid3(mw[0], mw[1], mw[2]) : mw[0]);
        end else if (mrej < 255) begin
            mrej++;
        end
        tick(1);
        sample_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && dist_valid) begin
            pulses++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_dist_valid: observed %0d expected none",
                       dist_cm);
            end
            if (sb.size() > 0) check("dist_cm", dist_cm, sb.pop_front());
        end
    end

    initial begin
        model_clear();
        tick(1);
        do_reset();
        check("rst_ready", sample_ready, 1);
        check("rst_dist", dist_cm, 25);
        check("rst_valid", dist_valid, 0);
        check("rst_stale", stale, 0);
        check("rst_reject", reject_cnt, 0);

        // basic window and median
        p0 = pulses;
        send(16'd100); tick(9);
        send(16'd102); tick(9);
        send(16'd500); tick(9);
        send(16'd98);  tick(9);
        check("basic_reject", reject_cnt, 1);
        check("basic_pulses", pulses - p0, 3);
        check("basic_dist", dist_cm, 100);

        // out-of-range only
        do_reset();
        p0 = pulses;
        send(16'hFFFF); tick(4);
        send(16'd1);    tick(4);
        send(16'd401);  tick(4);
        check("oor_pulses", pulses - p0, 0);
        check("oor_dist", dist_cm, 25);
        check("oor_reject", reject_cnt, mrej);

        // second strobe while busy is ignored; latency 3
        do_reset();
        send(16'd50);
        check("busy_ready_check", sample_ready, 0);
        sample_valid = 1'b1;
        sample_cm = 16'd60;
        tick(1);
        sample_valid = 1'b0;
        check("lat_n2_valid", dist_valid, 0);
        check("busy_ready_median", sample_ready, 0);
        tick(1);
        check("lat_n3_valid", dist_valid, 1);
        check("lat_n3_dist", dist_cm, 50);
        check("lat_n3_ready", sample_ready, 1);
        tick(1);
        check("lat_n4_valid", dist_valid, 0);
        tick(4);
        check("busy_dist_hold", dist_cm, 50);
        check("busy_reject", reject_cnt, 0);

        // duplicates
        do_reset();
        send(16'd5); tick(3);
        send(16'd9); tick(3);
        send(16'd5); tick(3);
        check("dup_dist", dist_cm, 5);

        // stale timeout restarts the window
        do_reset();
        send(16'd30); tick(3);
        send(16'd40); tick(3);
        send(16'd50);
        tick(30);
        check("stale_early", stale, 0);
        tick(15);
        check("stale_set", stale, 1);
        check("stale_dist_hold", dist_cm, 40);
        mfill = 0;
        send(16'd70); tick(3);
        check("stale_clear", stale, 0);
        check("stale_restart", dist_cm, 70);

        // reject counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 0) ? 16'd0 : 16'd1000);
            tick(1);
            if (i == 253) check("reject_254", reject_cnt, 254);
        end
        check("reject_sat", reject_cnt, 255);
        check("reject_model", reject_cnt, mrej);

        // reset during MEDIAN aborts the update and empties the window
        do_reset();
        send(16'd5); tick(3);
        send(16'd6); tick(3);
        p0 = pulses;
        send(16'd77);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("abort_valid", dist_valid, 0);
        check("abort_dist", dist_cm, 25);
        check("abort_ready", sample_ready, 1);
        reset = 1'b0;
        model_clear();
        tick(2);
        check("abort_pulses", pulses - p0, 0);
        send(16'd90); tick(3);
        check("abort_fill", dist_cm, 90);

        tick(2);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
